// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control unit.
// A Moore FSM sequences each instruction class through its phases; the
// datapath controls are registered alongside the state so they change
// cleanly on the clock edge. Write enables are gated by reset_n so nothing
// is written while reset is held, even though the reset state is FETCH.
//
// state    | meaning
// ---------+--------------------------------------------------
// FETCH    | read instruction, PC <= PC + 4
// DECODE   | read registers, compute branch/jump target
// MEMADR   | compute load/store address
// MEMREAD  | read data memory at ALUOut
// MEMWB    | write loaded data to register file
// MEMWRITE | write RD2 to data memory at ALUOut
// EXECUTER | register-register ALU operation
// ALUWB    | write ALU result to register file
// EXECUTEI | register-immediate ALU operation
// JAL      | PC <= target, compute link address
// BEQ      | compare operands, branch if zero
module multicycle_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ITYP = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t     state_q, state_d;
  logic       pcupdate_q, pcupdate_d;
  logic       branch_q, branch_d;
  logic       adrsrc_q, adrsrc_d;
  logic       memwrite_q, memwrite_d;
  logic       irwrite_q, irwrite_d;
  logic       regwrite_q, regwrite_d;
  logic [1:0] resultsrc_q, resultsrc_d;
  logic [1:0] alusrca_q, alusrca_d;
  logic [1:0] alusrcb_q, alusrcb_d;
  logic [1:0] aluop_q, aluop_d;

  // Next-state selection; unused encodings recover to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYP:      state_d = S_EXECUTER;
          OP_ITYP:      state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore output decode of the state being entered, so the registered
  // controls line up with state_q after the edge.
  always_comb begin
    pcupdate_d  = 1'b0;
    branch_d    = 1'b0;
    adrsrc_d    = 1'b0;
    memwrite_d  = 1'b0;
    irwrite_d   = 1'b0;
    regwrite_d  = 1'b0;
    resultsrc_d = 2'b00;
    alusrca_d   = 2'b00;
    alusrcb_d   = 2'b00;
    aluop_d     = 2'b00;
    case (state_d)
      S_FETCH: begin
        irwrite_d   = 1'b1;
        pcupdate_d  = 1'b1;
        alusrcb_d   = 2'b10;
        resultsrc_d = 2'b10;
      end
      S_DECODE: begin
        alusrca_d = 2'b01;
        alusrcb_d = 2'b01;
      end
      S_MEMADR: begin
        alusrca_d = 2'b10;
        alusrcb_d = 2'b01;
      end
      S_MEMREAD: adrsrc_d = 1'b1;
      S_MEMWB: begin
        resultsrc_d = 2'b01;
        regwrite_d  = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc_d   = 1'b1;
        memwrite_d = 1'b1;
      end
      S_EXECUTER: begin
        alusrca_d = 2'b10;
        aluop_d   = 2'b10;
      end
      S_EXECUTEI: begin
        alusrca_d = 2'b10;
        alusrcb_d = 2'b01;
        aluop_d   = 2'b10;
      end
      S_ALUWB: regwrite_d = 1'b1;
      S_BEQ: begin
        alusrca_d = 2'b10;
        aluop_d   = 2'b01;
        branch_d  = 1'b1;
      end
      S_JAL: begin
        alusrca_d  = 2'b01;
        alusrcb_d  = 2'b10;
        pcupdate_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State and control registers; reset lands in FETCH with FETCH controls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_FETCH;
      pcupdate_q  <= 1'b1;
      branch_q    <= 1'b0;
      adrsrc_q    <= 1'b0;
      memwrite_q  <= 1'b0;
      irwrite_q   <= 1'b1;
      regwrite_q  <= 1'b0;
      resultsrc_q <= 2'b10;
      alusrca_q   <= 2'b00;
      alusrcb_q   <= 2'b10;
      aluop_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      pcupdate_q  <= pcupdate_d;
      branch_q    <= branch_d;
      adrsrc_q    <= adrsrc_d;
      memwrite_q  <= memwrite_d;
      irwrite_q   <= irwrite_d;
      regwrite_q  <= regwrite_d;
      resultsrc_q <= resultsrc_d;
      alusrca_q   <= alusrca_d;
      alusrcb_q   <= alusrcb_d;
      aluop_q     <= aluop_d;
    end
  end

  // ALU operation from aluop, refined by funct3 for ALU-class instructions.
  always_comb begin
    alucontrol = 3'b000;
    case (aluop_q)
      2'b01: alucontrol = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alucontrol = ({op[5], funct7b5} == 2'b11) ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b100:  alucontrol = 3'b100;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

  // Immediate format follows the opcode directly.
  always_comb begin
    immsrc = 2'b00;
    case (op)
      OP_SW:   immsrc = 2'b01;
      OP_BEQ:  immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

  // Enables are forced low while reset is held; branch resolves with zero
  // in the same cycle.
  assign pcwrite   = reset_n & (pcupdate_q | (branch_q & zero));
  assign irwrite   = reset_n & irwrite_q;
  assign regwrite  = reset_n & regwrite_q;
  assign memwrite  = reset_n & memwrite_q;
  assign adrsrc    = adrsrc_q;
  assign resultsrc = resultsrc_q;
  assign alusrca   = alusrca_q;
  assign alusrcb   = alusrcb_q;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed and random instructions compared
// against an instruction-level model of phase sequences and per-phase controls.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  int seq_q[$];

  multicycle_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .pcwrite(pcwrite), .adrsrc(adrsrc),
    .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .immsrc(immsrc), .alucontrol(alucontrol), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  wire [15:0] obs_vec = {pcwrite, adrsrc, memwrite, irwrite, regwrite,
                         resultsrc, alusrca, alusrcb, immsrc, alucontrol};
  wire [3:0]  obs_en  = {pcwrite, irwrite, regwrite, memwrite};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Phases each instruction class walks through, starting at FETCH.
  function automatic void build_seq(input logic [6:0] o);
    case (o)
      7'b0000011: seq_q = '{0, 1, 2, 3, 4};
      7'b0100011: seq_q = '{0, 1, 2, 5};
      7'b0110011: seq_q = '{0, 1, 6, 7};
      7'b0010011: seq_q = '{0, 1, 8, 7};
      7'b1101111: seq_q = '{0, 1, 9, 7};
      7'b1100011: seq_q = '{0, 1, 10};
      default:    seq_q = '{0, 1};
    endcase
  endfunction

  // Expected controls for a phase, given the instruction fields and zero.
  function automatic logic [15:0] model_out(input int s, input logic [6:0] o,
                                            input logic [2:0] f3, input logic f7,
                                            input logic z);
    logic pcup = 0, br = 0, irw = 0, adr = 0, mw = 0, rw = 0;
    logic [1:0] rs = 0, sa = 0, sb = 0, aluop = 0, imm = 0;
    logic [2:0] alu = 0;
    case (s)
      0:  begin irw = 1; pcup = 1; sb = 2; rs = 2; end
      1:  begin sa = 1; sb = 1; end
      2:  begin sa = 2; sb = 1; end
      3:  adr = 1;
      4:  begin rs = 1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin sa = 2; aluop = 2; end
      7:  rw = 1;
      8:  begin sa = 2; sb = 1; aluop = 2; end
      9:  begin sa = 1; sb = 2; pcup = 1; end
      10: begin sa = 2; aluop = 1; br = 1; end
      default: ;
    endcase
    if (aluop == 1) alu = 3'd1;
    else if (aluop == 2) begin
      case (f3)
        3'd0: alu = (o[5] && f7) ? 3'd1 : 3'd0;
        3'd2: alu = 3'd5;
        3'd4: alu = 3'd4;
        3'd6: alu = 3'd3;
        3'd7: alu = 3'd2;
        default: alu = 3'd0;
      endcase
    end
    case (o)
      7'b0100011: imm = 1;
      7'b1100011: imm = 2;
      7'b1101111: imm = 3;
      default:    imm = 0;
    endcase
    return {pcup | (br & z), adr, mw, irw, rw, rs, sa, sb, imm, alu};
  endfunction

  // Run one instruction; entered just after the edge that put the DUT in FETCH.
  // zmode < 0 randomizes zero each cycle, otherwise holds it at zmode.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input int zmode);
    #1;
    op = o; funct3 = f3; funct7b5 = f7;
    build_seq(o);
    foreach (seq_q[i]) begin
      zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      @(negedge clk);
      check($sformatf("state op=%b step%0d", o, i), 32'(state), 32'(seq_q[i]));
      check($sformatf("outs op=%b st=%0d", o, seq_q[i]), 32'(obs_vec),
            32'(model_out(seq_q[i], o, f3, f7, zero)));
      @(posedge clk);
      #1;
    end
    check($sformatf("ret op=%b", o), 32'(state), 32'd0);
  endtask

  logic [6:0] op_tbl [7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                             7'b1101111, 7'b1100011, 7'b1111111};

  initial begin
    reset_n = 1'b0; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; zero = 1'b0;
    #2;
    check("reset state", 32'(state), 32'd0);
    check("reset enables", 32'(obs_en), 32'd0);
    #4 reset_n = 1'b1;  // t=6, just after the first rising edge

    run_instr(7'b0000011, 3'd2, 1'b0, -1);   // lw
    run_instr(7'b0100011, 3'd2, 1'b0, -1);   // sw
    run_instr(7'b1100011, 3'd0, 1'b0, 1);    // beq taken
    run_instr(7'b1100011, 3'd0, 1'b0, 0);    // beq not taken
    run_instr(7'b0110011, 3'd0, 1'b1, -1);   // sub
    run_instr(7'b0110011, 3'd0, 1'b0, -1);   // add
    run_instr(7'b0110011, 3'd2, 1'b0, -1);   // slt
    run_instr(7'b0010011, 3'd0, 1'b1, -1);   // addi with bit30 set stays add
    run_instr(7'b1101111, 3'd0, 1'b0, -1);   // jal
    run_instr(7'b1111111, 3'd0, 1'b0, -1);   // illegal

    for (int n = 0; n < 60; n++) begin
      logic [6:0] o;
      o = ($urandom_range(0, 7) == 7) ? 7'($urandom) : op_tbl[$urandom_range(0, 6)];
      run_instr(o, 3'($urandom), 1'($urandom), -1);
    end

    // Reset while in MEMWRITE.
    #1;
    op = 7'b0100011; funct3 = 3'd2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre-reset state", 32'(state), 32'd5);
    check("pre-reset memwrite", 32'(memwrite), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("async reset state", 32'(state), 32'd0);
    check("async reset memwrite", 32'(memwrite), 32'd0);
    check("async reset enables", 32'(obs_en), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("held reset state", 32'(state), 32'd0);
      check("held reset enables", 32'(obs_en), 32'd0);
    end
    #1 reset_n = 1'b1;
    op = 7'b1111111;
    #1;
    check("post-reset irwrite", 32'(irwrite), 32'd1);
    check("post-reset pcwrite", 32'(pcwrite), 32'd1);
    @(posedge clk);
    #1 check("post-reset decode", 32'(state), 32'd1);
    @(posedge clk);
    #1 check("post-reset refetch", 32'(state), 32'd0);

    run_instr(7'b0000011, 3'd2, 1'b0, -1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: reset_n  in  1  async active-low reset.
REQ-004 SHALL have port: op  in  7  instruction opcode, from the instruction register.
REQ-005 SHALL have port: funct3  in  3  instruction funct3.
REQ-006 SHALL have port: funct7b5  in  1  instruction bit 30.
REQ-007 SHALL have port: zero  in  1  ALU zero flag.
REQ-008 SHALL have port: pcwrite  out  1  PC register enable.
REQ-009 SHALL have port: adrsrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 SHALL have port: memwrite  out  1  data memory write enable.
REQ-011 SHALL have port: irwrite  out  1  instruction register enable.
REQ-012 SHALL have port: regwrite  out  1  register file write enable.
REQ-013 SHALL have port: resultsrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-014 SHALL have port: alusrca  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
REQ-015 SHALL have port: alusrcb  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
REQ-016 SHALL have port: immsrc  out  2  immediate format select.
REQ-017 SHALL have port: alucontrol  out  3  ALU operation code.
REQ-018 SHALL have port: state  out  4  current FSM state, for debug.

Function
REQ-019 SHALL implement a Moore FSM with these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10.
REQ-020 SHALL transition as follows:
- FETCH -> DECODE.
- DECODE -> MEMADR for op 0000011 or 0100011.
- DECODE -> EXECUTER for op 0110011.
- DECODE -> EXECUTEI for op 0010011.
- DECODE -> JAL for op 1101111.
- DECODE -> BEQ for op 1100011.
- DECODE -> FETCH for any other op.
REQ-021 SHALL transition as follows:
- MEMADR -> MEMREAD for op 0000011; otherwise MEMADR -> MEMWRITE.
- MEMREAD -> MEMWB.
- EXECUTER, EXECUTEI and JAL -> ALUWB.
- MEMWB, MEMWRITE, ALUWB and BEQ -> FETCH.
- Unused encodings 11-15 -> FETCH.
REQ-022 SHALL drive these Moore outputs per state; any field not listed is 0:
- FETCH: irwrite=1, pcupdate=1, alusrcb=10, resultsrc=10, aluop=00.
- DECODE: alusrca=01, alusrcb=01, aluop=00.
- MEMADR: alusrca=10, alusrcb=01, aluop=00.
- MEMREAD: adrsrc=1.
- MEMWB: resultsrc=01, regwrite=1.
- MEMWRITE: adrsrc=1, memwrite=1.
REQ-023 SHALL drive these Moore outputs per state; any field not listed is 0:
- EXECUTER: alusrca=10, aluop=10.
- EXECUTEI: alusrca=10, alusrcb=01, aluop=10.
- ALUWB: regwrite=1.
- BEQ: alusrca=10, aluop=01, branch=1.
- JAL: alusrca=01, alusrcb=10, pcupdate=1.
REQ-024 SHALL compute pcwrite = pcupdate | (branch & zero) combinationally within the same cycle as zero.
REQ-025 SHALL decode alucontrol combinationally from aluop:
- aluop=00 -> 000 (add).
- aluop=01 -> 001 (sub).
- aluop=11 -> 000.
REQ-026 SHALL decode alucontrol for aluop=10 from funct3:
- 000 -> 001 if {op[5], funct7b5}=11, else 000.
- 010 -> 101 (slt).
- 100 -> 100 (xor).
- 110 -> 011 (or).
- 111 -> 010 (and).
- any other funct3 -> 000.
REQ-027 SHALL decode immsrc from op:
- 0000011 -> 00.
- 0010011 -> 00.
- 0100011 -> 01.
- 1100011 -> 10.
- 1101111 -> 11.
- any other op -> 00.
REQ-028 SHALL give each instruction class this latency in cycles from FETCH to the next FETCH:
- lw = 5.
- sw = 4.
- R-type = 4.
- I-type ALU = 4.
- jal = 4.
- beq = 3.
- illegal op = 2.
REQ-029 SHALL leave all outputs free of X under every input combination.

Reset
REQ-030 SHALL force state to FETCH immediately on reset_n falling, without waiting for clk.
REQ-031 SHALL hold pcwrite, irwrite, regwrite and memwrite at 0 while reset_n=0, overriding the FETCH decode.
REQ-032 SHALL perform the FETCH actions on the first rising clk edge after reset_n rises, then move to DECODE.
REQ-033 SHALL, if reset_n is asserted mid-instruction, abort that instruction and issue no further write enables.

Verification
REQ-034 SHALL cover lw (op 0000011): state sequence 0,1,2,3,4,0; regwrite=1 only in state 4 with resultsrc=01; immsrc=00.
REQ-035 SHALL cover sw (op 0100011): state sequence 0,1,2,5,0; memwrite=1 and adrsrc=1 only in state 5; immsrc=01.
REQ-036 SHALL cover beq (op 1100011) in state BEQ: zero=1 -> pcwrite=1 and alucontrol=001; zero=0 -> pcwrite=0; next state FETCH in both cases.
REQ-037 SHALL cover sub (op 0110011, funct3 000, funct7b5 1): alucontrol=001 in EXECUTER; with funct7b5=0, alucontrol=000; slt (funct3 010) gives alucontrol=101.
REQ-038 SHALL cover reset_n driven low while in MEMWRITE: state becomes 0 before the next clk edge, memwrite=0, and all enables stay 0 until reset_n rises.
REQ-039 SHALL cover illegal op 1111111: state sequence 0,1,0; regwrite=0 and memwrite=0 throughout.
